// File: rtl/fft_cap_pkg.sv
// fft_result_capture shared types and defaults
// FSM states and default frame geometry
package fft_cap_pkg;

  localparam int FFT_N_POINTS = 1024;
  localparam int FFT_DW       = 12;
  localparam int FFT_EXPW     = 6;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DRAIN   = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

endpackage

// File: rtl/fft_result_capture_ram.sv
// Magnitude frame buffer
// One write port, one registered read port
module fft_mag_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int MW    = 25
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [MW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [MW-1:0] o_rdata
);

  logic [MW-1:0] r_mem [DEPTH];
  logic [MW-1:0] r_rdata;

  // array write, no reset so it maps to block RAM
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // registered read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rdata <= '0;
    else        r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fft_result_capture.sv
// FFT output capture: |X|^2 buffer, peak,
// block exponent, held until acknowledged
module fft_result_capture
  import fft_cap_pkg::*;
#(
  parameter int N_POINTS = FFT_N_POINTS,
  parameter int DW       = FFT_DW,
  parameter int EXPW     = FFT_EXPW,
  parameter int AW       = $clog2(N_POINTS),
  parameter int MW       = 2*DW+1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            fft_valid,
  output logic            fft_ready,
  input  logic [1:0]      fft_error,
  input  logic            fft_sop,
  input  logic            fft_eop,
  input  logic [DW-1:0]   fft_real,
  input  logic [DW-1:0]   fft_imag,
  input  logic [EXPW-1:0] fft_exp,
  input  logic [AW-1:0]   rd_addr,
  output logic [MW-1:0]   rd_data,
  output logic            frame_done,
  input  logic            frame_ack,
  output logic [AW-1:0]   peak_bin,
  output logic [MW-1:0]   peak_mag,
  output logic [EXPW-1:0] frame_exp,
  output logic            frame_err,
  output logic            len_err
);

  localparam logic [AW-1:0] LAST = AW'(N_POINTS-1);

  state_t r_state;
  state_t w_next;

  logic            r_run;
  logic [AW-1:0]   r_idx;
  logic            r_err_acc;
  logic [EXPW-1:0] r_frame_exp;
  logic            r_len_err;

  logic                 r_s1_valid;
  logic                 r_s1_last;
  logic [AW-1:0]        r_s1_idx;
  logic [2*DW-1:0]      r_sq_re;
  logic [2*DW-1:0]      r_sq_im;
  logic                 r_s2_last;

  logic [AW-1:0] r_pk_bin;
  logic [MW-1:0] r_pk_mag;

  logic            r_frame_done;
  logic [AW-1:0]   r_peak_bin;
  logic [MW-1:0]   r_peak_mag;
  logic            r_frame_err;

  logic w_accept;
  logic w_cap;
  logic w_start;
  logic w_restart;
  logic w_last_ok;
  logic w_len_viol;
  logic w_cap_beat;
  logic w_done;
  logic [AW-1:0] w_beat_idx;

  logic signed [2*DW-1:0] w_re_x;
  logic signed [2*DW-1:0] w_im_x;
  logic signed [2*DW-1:0] w_sq_re;
  logic signed [2*DW-1:0] w_sq_im;
  logic [MW-1:0]          w_sum;

  assign w_accept   = fft_valid && fft_ready;
  assign w_cap      = (r_state == S_CAPTURE);
  assign w_start    = w_accept && fft_sop;
  assign w_restart  = w_start && w_cap;
  assign w_last_ok  = w_accept && w_cap && !fft_sop &&
                      fft_eop && (r_idx == LAST);
  assign w_len_viol = w_accept && w_cap && !fft_sop &&
                      (fft_eop != (r_idx == LAST));
  assign w_cap_beat = w_accept && (w_cap || fft_sop);
  assign w_beat_idx = fft_sop ? '0 : r_idx;
  assign w_done     = (r_state == S_DRAIN) && r_s2_last;

  // full-precision signed squares; -2^(DW-1) squared fits
  assign w_re_x  = {{DW{fft_real[DW-1]}}, fft_real};
  assign w_im_x  = {{DW{fft_imag[DW-1]}}, fft_imag};
  assign w_sq_re = w_re_x * w_re_x;
  assign w_sq_im = w_im_x * w_im_x;
  assign w_sum   = MW'(r_sq_re) + MW'(r_sq_im);

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (w_start)         w_next = S_CAPTURE;
        else if (w_last_ok)  w_next = S_DRAIN;
        else if (w_len_viol) w_next = S_IDLE;
      end
      S_DRAIN: begin
        if (r_s2_last) w_next = S_HOLD;
      end
      S_HOLD: begin
        if (frame_ack) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // backpressure: open only while idle or capturing
  always_comb begin
    fft_ready = 1'b0;
    case (r_state)
      S_IDLE:    fft_ready = r_run;
      S_CAPTURE: fft_ready = r_run;
      default:   fft_ready = 1'b0;
    endcase
  end

  // frame bookkeeping: index, exponent, error, length flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run       <= 1'b0;
      r_idx       <= '0;
      r_err_acc   <= 1'b0;
      r_frame_exp <= '0;
      r_len_err   <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_start) begin
        r_idx       <= AW'(1);
        r_frame_exp <= fft_exp;
        r_err_acc   <= |fft_error;
      end else if (w_accept && w_cap) begin
        r_idx     <= r_idx + AW'(1);
        r_err_acc <= r_err_acc | (|fft_error);
      end
      if (w_restart || w_len_viol)
        r_len_err <= 1'b1;
      else if (r_state == S_HOLD && frame_ack)
        r_len_err <= 1'b0;
    end
  end

  // pipeline stage 1: squares, index, last-beat tag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_idx   <= '0;
      r_sq_re    <= '0;
      r_sq_im    <= '0;
    end else begin
      r_s1_valid <= w_cap_beat;
      r_s1_last  <= w_last_ok;
      r_s1_idx   <= w_beat_idx;
      r_sq_re    <= w_sq_re;
      r_sq_im    <= w_sq_im;
    end
  end

  // pipeline stage 2: running peak (a new sop discards
  // any beat still in flight from the previous frame)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_last <= 1'b0;
      r_pk_bin  <= '0;
      r_pk_mag  <= '0;
    end else begin
      r_s2_last <= r_s1_valid && r_s1_last;
      if (w_start) begin
        r_pk_bin <= '0;
        r_pk_mag <= '0;
      end else if (r_s1_valid && (w_sum > r_pk_mag)) begin
        r_pk_bin <= r_s1_idx;
        r_pk_mag <= w_sum;
      end
    end
  end

  // publish results only for a complete frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_done <= 1'b0;
      r_peak_bin   <= '0;
      r_peak_mag   <= '0;
      r_frame_err  <= 1'b0;
    end else begin
      r_frame_done <= w_done;
      if (w_done) begin
        r_peak_bin  <= r_pk_bin;
        r_peak_mag  <= r_pk_mag;
        r_frame_err <= r_err_acc;
      end
    end
  end

  fft_mag_ram #(
    .DEPTH (N_POINTS),
    .AW    (AW),
    .MW    (MW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_we    (r_s1_valid),
    .i_waddr (r_s1_idx),
    .i_wdata (w_sum),
    .i_raddr (rd_addr),
    .o_rdata (rd_data)
  );

  assign frame_done = r_frame_done;
  assign peak_bin   = r_peak_bin;
  assign peak_mag   = r_peak_mag;
  assign frame_exp  = r_frame_exp;
  assign frame_err  = r_frame_err;
  assign len_err    = r_len_err;

endmodule
